// File: rtl/sram_arbiter.sv
// sram_arbiter
// -----------------------------------------------------------------------------
// Shares one single-port SRAM between two requesters: port A, usually the
// processor, and port B, usually a loader or a debug/DMA engine.
//
// Arbitration
// - Grants are registered. A request sampled at a rising edge is granted after
//   that edge.
// - When both ports request at the same edge, round-robin decides the winner.
// - A burst limit applies while the other port is waiting. After MAX_BURST
//   granted cycles the owner is preempted, so neither port starves.
//
// Memory steering is combinational from the grant state. Read data from the
// SRAM goes back to both ports unchanged.
//
// Parameters
//   word_size  data width
//   addr_size  address width
//   MAX_BURST  granted cycles allowed while the other port waits (>= 1)
//   CNT_W      burst counter width; must hold MAX_BURST-1
//
// Ports
//   clk                       rising-edge clock
//   rst                       asynchronous active-low reset
//   req_x/we_x/addr_x/wdata_x per-port request, write enable, address, data
//   gnt_x                     per-port grant (registered state)
//   rdata_x                   per-port read data (copy of mem_dout)
//   mem_addr/mem_din          to the SRAM: address and write data
//   mem_write                 to the SRAM: write strobe
//   mem_dout                  from the SRAM: combinational read data
//   busy                      either port currently owns the memory
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int word_size = 8,
  parameter int addr_size = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_a,
  input  logic                 we_a,
  input  logic [addr_size-1:0] addr_a,
  input  logic [word_size-1:0] wdata_a,
  output logic                 gnt_a,
  output logic [word_size-1:0] rdata_a,
  input  logic                 req_b,
  input  logic                 we_b,
  input  logic [addr_size-1:0] addr_b,
  input  logic [word_size-1:0] wdata_b,
  output logic                 gnt_b,
  output logic [word_size-1:0] rdata_b,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_din,
  output logic                 mem_write,
  input  logic [word_size-1:0] mem_dout,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  // The owner is preempted once the counter has reached this value while the
  // other port is still waiting.
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  state_t           r_state;
  state_t           w_state_next;
  // Last owner flag: 0 means A owned last, 1 means B owned last.
  logic             r_last_b;
  logic             w_last_b_next;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_cnt_next;
  logic             w_other_req;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_last_b    <= 1'b1;  // port A wins the first tie after reset
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_last_b    <= w_last_b_next;
      r_burst_cnt <= w_burst_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_a && req_b) begin
          w_state_next = r_last_b ? OWN_A : OWN_B;
        end else if (req_a) begin
          w_state_next = OWN_A;
        end else if (req_b) begin
          w_state_next = OWN_B;
        end
      end
      OWN_A: begin
        // When the owner releases, a waiting port takes over directly,
        // without an idle cycle in between.
        if (!req_a) begin
          w_state_next = req_b ? OWN_B : IDLE;
        end else if (req_b && (r_burst_cnt == BURST_LAST)) begin
          w_state_next = OWN_B;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          w_state_next = req_a ? OWN_A : IDLE;
        end else if (req_a && (r_burst_cnt == BURST_LAST)) begin
          w_state_next = OWN_A;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Request from the port that does not currently own the memory.
  always_comb begin
    w_other_req = 1'b0;
    case (r_state)
      OWN_A:   w_other_req = req_b;
      OWN_B:   w_other_req = req_a;
      default: w_other_req = 1'b0;
    endcase
  end

  // The counter clears on every ownership change. It counts only cycles in
  // which the other port is waiting. It stops at BURST_LAST and never wraps.
  always_comb begin
    w_burst_cnt_next = r_burst_cnt;
    if (w_state_next != r_state) begin
      w_burst_cnt_next = '0;
    end else if (w_other_req && (r_burst_cnt != BURST_LAST)) begin
      w_burst_cnt_next = r_burst_cnt + CNT_W'(1);
    end
  end

  // The last-owner flag is updated only when a port newly enters ownership.
  always_comb begin
    w_last_b_next = r_last_b;
    if (w_state_next != r_state) begin
      if (w_state_next == OWN_A) begin
        w_last_b_next = 1'b0;
      end else if (w_state_next == OWN_B) begin
        w_last_b_next = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gnt_a = (r_state == OWN_A);
  assign gnt_b = (r_state == OWN_B);
  assign busy  = gnt_a | gnt_b;

  // Only the owner's signals reach the SRAM. A write enable from the other
  // port is dropped here, so it can never reach memory.
  always_comb begin
    mem_addr  = '0;
    mem_din   = '0;
    mem_write = 1'b0;
    case (r_state)
      OWN_A: begin
        mem_addr  = addr_a;
        mem_din   = wdata_a;
        mem_write = we_a;
      end
      OWN_B: begin
        mem_addr  = addr_b;
        mem_din   = wdata_b;
        mem_write = we_b;
      end
      default: begin
        mem_addr  = '0;
        mem_din   = '0;
        mem_write = 1'b0;
      end
    endcase
  end

  assign rdata_a = mem_dout;
  assign rdata_b = mem_dout;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter.
// The bench holds a 256x8 SRAM with combinational read, connected to the
// arbiter. A behavioural model tracks ownership and expected memory contents.
// A compare process checks every DUT output against that model on each falling
// edge. Directed scenarios add hand-computed literal checks.
module tb_sram_arbiter;
  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [7:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
  logic       gnt_a, gnt_b, mem_write, busy;
  logic [7:0] rdata_a, rdata_b, mem_addr, mem_din, mem_dout;

  logic [7:0] sram [256];
  logic [7:0] m_mem [256];
  int         m_owner = 0;  // 0 none, 1 A, 2 B
  int         m_last  = 2;
  int         m_held  = 0;  // granted cycles during which the other port waited
  int         total = 0;
  int         bad   = 0;

  sram_arbiter #(
    .word_size(8),
    .addr_size(8),
    .MAX_BURST(MAXB),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_a(req_a),
    .we_a(we_a),
    .addr_a(addr_a),
    .wdata_a(wdata_a),
    .gnt_a(gnt_a),
    .rdata_a(rdata_a),
    .req_b(req_b),
    .we_b(we_b),
    .addr_b(addr_b),
    .wdata_b(wdata_b),
    .gnt_b(gnt_b),
    .rdata_b(rdata_b),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_write(mem_write),
    .mem_dout(mem_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM: combinational read, write at the rising edge.
  assign mem_dout = sram[mem_addr];
  always @(posedge clk) begin
    if (mem_write) sram[mem_addr] <= mem_din;
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]  = 8'(i) ^ 8'hA5;
      m_mem[i] = 8'(i) ^ 8'hA5;
    end
    sram[8'h10]  = 8'h5A;
    m_mem[8'h10] = 8'h5A;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Model update at each rising edge, from the ownership rules.
  initial begin : model
    int nxt, other_port;
    bit mine, other;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_owner = 0;
        m_last  = 2;
        m_held  = 0;
      end else begin
        if (m_owner == 1 && we_a) m_mem[addr_a] = wdata_a;
        if (m_owner == 2 && we_b) m_mem[addr_b] = wdata_b;
        if (m_owner == 0) begin
          if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
          else if (req_a)     nxt = 1;
          else if (req_b)     nxt = 2;
          else                nxt = 0;
        end else begin
          mine       = (m_owner == 1) ? req_a : req_b;
          other      = (m_owner == 1) ? req_b : req_a;
          other_port = 3 - m_owner;
          if (!mine) begin
            nxt = other ? other_port : 0;
          end else if (other) begin
            m_held++;
            nxt = (m_held >= MAXB) ? other_port : m_owner;
          end else begin
            nxt = m_owner;
          end
        end
        if (nxt != m_owner) begin
          m_held = 0;
          if (nxt != 0) m_last = nxt;
        end
        m_owner = nxt;
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  initial begin : compare
    int eo;
    logic [7:0] e_addr, e_din;
    logic e_we;
    forever begin
      @(negedge clk);
      eo     = rst ? m_owner : 0;
      e_addr = (eo == 1) ? addr_a  : (eo == 2) ? addr_b  : 8'h00;
      e_din  = (eo == 1) ? wdata_a : (eo == 2) ? wdata_b : 8'h00;
      e_we   = (eo == 1) ? we_a    : (eo == 2) ? we_b    : 1'b0;
      check("cyc_gnt_a", int'(gnt_a), int'(eo == 1));
      check("cyc_gnt_b", int'(gnt_b), int'(eo == 2));
      check("cyc_busy", int'(busy), int'(eo != 0));
      check("cyc_excl", int'(gnt_a & gnt_b), 0);
      check("cyc_mem_addr", int'(mem_addr), int'(e_addr));
      check("cyc_mem_din", int'(mem_din), int'(e_din));
      check("cyc_mem_write", int'(mem_write), int'(e_we));
      check("cyc_rdata_a", int'(rdata_a), int'(m_mem[e_addr]));
      check("cyc_rdata_b", int'(rdata_b), int'(m_mem[e_addr]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus with literal expectations.
  initial begin : stim
    int cnt;
    #1;
    check("rst_gnt_a", int'(gnt_a), 0);
    check("rst_gnt_b", int'(gnt_b), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_write", int'(mem_write), 0);
    tick(); tick();
    rst = 1'b1;

    // Single read.
    req_a = 1; addr_a = 8'h10;
    #1 check("read_gnt_latency", int'(gnt_a), 0);
    tick();
    check("read_gnt_a", int'(gnt_a), 1);
    check("read_gnt_b", int'(gnt_b), 0);
    check("read_rdata_a", int'(rdata_a), 'h5A);
    req_a = 0;
    tick();
    check("read_release_busy", int'(busy), 0);

    // Tie after reset: A wins, handoff to B without a gap, then A wins the next tie.
    rst = 0; tick(); rst = 1;
    req_a = 1; req_b = 1;
    tick();
    check("tie_gnt_a", int'(gnt_a), 1);
    check("tie_gnt_b", int'(gnt_b), 0);
    req_a = 0;
    tick();
    check("handoff_gnt_b", int'(gnt_b), 1);
    check("handoff_gnt_a", int'(gnt_a), 0);
    req_b = 0;
    tick();
    check("handoff_idle", int'(busy), 0);
    req_a = 1; req_b = 1;
    tick();
    check("tie2_gnt_a", int'(gnt_a), 1);

    // Preemption: A holds the grant; B waits; A has exactly MAXB granted cycles.
    req_b = 0;
    tick(); tick();
    req_b = 1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (gnt_b) break;
      if (gnt_a) cnt++;
      tick();
    end
    check("preempt_cycles", cnt, 4);
    check("preempt_gnt_b", int'(gnt_b), 1);
    check("preempt_gnt_a", int'(gnt_a), 0);
    tick();
    req_b = 0;
    tick();
    check("regain_gnt_a", int'(gnt_a), 1);
    req_a = 0;
    tick();

    // Write isolation.
    req_a = 1; addr_a = 8'h20;
    tick();
    req_b = 1; we_b = 1; addr_b = 8'h20; wdata_b = 8'hFF;
    #1 check("iso_mem_write", int'(mem_write), 0);
    tick(); tick();
    check("iso_mem20", int'(sram[8'h20]), 'h85);
    req_b = 0; we_b = 0;
    we_a = 1; wdata_a = 8'h33;
    #1 check("wr_mem_write", int'(mem_write), 1);
    tick();
    we_a = 0;
    #1 check("wr_readback", int'(rdata_a), 'h33);
    req_a = 0;
    tick();

    // Reset in the middle of a write cycle.
    req_a = 1; we_a = 1; addr_a = 8'h30; wdata_a = 8'hC3;
    tick();
    check("rmw_gnt_a", int'(gnt_a), 1);
    #2 rst = 0;
    #1;
    check("rmw_gnt_drop", int'(gnt_a), 0);
    check("rmw_write_drop", int'(mem_write), 0);
    tick();
    check("rmw_mem30", int'(sram[8'h30]), 'h95);
    we_a = 0; req_b = 1; rst = 1;
    tick();
    check("rmw_first_a", int'(gnt_a), 1);
    check("rmw_first_b", int'(gnt_b), 0);

    // Idle: no requests, with port A driving write signals anyway.
    req_a = 0; req_b = 0; we_a = 1; addr_a = 8'h44; wdata_a = 8'h77;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("idle_busy", int'(busy), 0);
      check("idle_mem_write", int'(mem_write), 0);
      check("idle_mem_addr", int'(mem_addr), 0);
      tick();
    end
    we_a = 0;
    check("final_mem20", int'(sram[8'h20]), 'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time limit in case the run fails to end on its own.
  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single-port 256x8 SRAM between the processor (port A) and a second requester such as a program loader or debug/DMA engine (port B). It sits between both requesters and the memory. It grants exclusive access with a registered req/gnt handshake, uses round-robin on ties, and applies a burst limit so neither port starves. It steers address, write data and write strobe to the memory and fans read data back to both ports.

## Interface
Parameters:
- word_size, 8, data width
- addr_size, 8, address width
- MAX_BURST, 4, consecutive granted cycles allowed while the other port is waiting (≥1)
- CNT_W, 3, burst counter width; must hold MAX_BURST-1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_a  in  1  port A requests access
- we_a  in  1  port A write enable
- addr_a  in  addr_size  port A address
- wdata_a  in  word_size  port A write data
- gnt_a  out  1  port A owns memory (registered)
- rdata_a  out  word_size  read data to port A (= mem_dout)
- req_b, we_b, addr_b, wdata_b, gnt_b, rdata_b: same as port A, for port B
- mem_addr  out  addr_size  to SRAM address
- mem_din  out  word_size  to SRAM data_in
- mem_write  out  1  to SRAM write
- mem_dout  in  word_size  from SRAM data_out (combinational read)
- busy  out  1  gnt_a | gnt_b

## Operation
- FSM states: IDLE, OWN_A, OWN_B. Encoded in a state register; gnt_a = (state==OWN_A) and gnt_b = (state==OWN_B).
- A last_owner flag is updated on every entry into OWN_A or OWN_B.
- IDLE:
  - Only req_a → OWN_A. Only req_b → OWN_B. Neither → stay.
  - Both → the port that is not last_owner.
- OWN_x, owner keeps req_x high, other port idle: stay. No limit on hold length.
- OWN_x, owner drops req_x: other port requesting → go directly to OWN_other (no idle cycle); otherwise → IDLE.
- OWN_x, other port requesting, burst_cnt == MAX_BURST-1 → preempt to OWN_other. The preempted port sees its gnt drop and must keep req high to regain access.
- burst_cnt:
  - Clears on any state change.
  - Increments each cycle in OWN_x while the other req is high.
  - Holds while the other req is low.
  - Saturates; never wraps.
- Memory steering (combinational from state):
  - OWN_A: mem_addr=addr_a, mem_din=wdata_a, mem_write=we_a.
  - OWN_B: the same, from port B.
  - IDLE: all zero.
- Writes from a non-granted port never reach memory. we_x without gnt_x is ignored silently.
- rdata_a and rdata_b both equal mem_dout at all times. The value is meaningful only to the granted port.

## Timing
- Reset (async, immediate): state=IDLE, last_owner=B (port A wins first tie), burst_cnt=0, gnt_a=gnt_b=0, busy=0, mem_addr=0, mem_din=0, mem_write=0.
- Grant latency:
  - req sampled at edge N → gnt high after edge N, from IDLE.
  - Minimum one cycle from req assertion to gnt.
- Read: in a granted cycle, rdata reflects addr in the same cycle (zero-cycle memory read).
- Write: commits at the rising edge that ends a cycle with gnt_x=1 and we_x=1.
- Release: req_x low at edge N → gnt_x low after edge N. The other port's gnt rises after the same edge, with no overlap and no gap.
- Preemption: with other port waiting, owner holds gnt for exactly MAX_BURST cycles, then gnt switches.
- Reset asserted mid-write: gnt and mem_write drop immediately, with no edge required. A write in progress is not committed unless its edge preceded reset.
- Simultaneous release by the owner and request by the other port: handoff as in Release.
- gnt_a and gnt_b are never both 1.

## Test plan
- Single read: after reset, req_a=1, addr_a=8'h10, memory[8'h10]=8'h5A → gnt_a=1 one cycle later, rdata_a=8'h5A; gnt_b stays 0.
- Tie after reset: req_a=req_b=1 at the same edge → OWN_A first. Then A drops req → gnt_b=1 on the next cycle with no idle cycle; last_owner=B.
- Preemption (MAX_BURST=4): A granted and holds req; B raises req → gnt_a stays high for exactly 4 cycles counted from B's request, then gnt_b=1 and gnt_a=0; A regains access after B releases.
- Write isolation: A owns memory; B drives we_b=1, addr_b=8'h20, wdata_b=8'hFF → memory[8'h20] unchanged. A writes 8'h33 to 8'h20 → readback returns 8'h33.
- Reset mid-write: A granted with we_a=1; rst=0 mid-cycle → gnt_a=0 and mem_write=0 immediately, target location unchanged. After rst=1 with both requesting → A granted first.
- Idle output: no requests for 10 cycles → busy=0, mem_write=0, mem_addr=0 throughout.
